// File: rtl/muldiv_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_hilo_ctrl
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//                Multiplies finish after MUL_LATENCY edges. Divides use an
//                iterative restoring divider plus a sign-fix state.
//                Define MULDIV_DIV_EN to build the divider. Without it,
//                DIV/DIVU finish in one edge and leave HI/LO unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_hilo_ctrl #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam int         CW       = $clog2(WIDTH + MUL_LATENCY) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic             mul_signed_q, mul_signed_d;
    logic             done_q, done_d, dbz_q, dbz_d;
    logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod;
`ifdef MULDIV_DIV_EN
    // quo_q starts as the dividend magnitude and shifts quotient bits in.
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic             w_div_signed, w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic [WIDTH:0]   w_shift, w_diff;
`endif

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    // State, operand and HI/LO registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            mul_signed_q <= 1'b0;
            done_q       <= 1'b0;
            dbz_q        <= 1'b0;
`ifdef MULDIV_DIV_EN
            rem_q        <= '0;
            quo_q        <= '0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            mul_signed_q <= mul_signed_d;
            done_q       <= done_d;
            dbz_q        <= dbz_d;
`ifdef MULDIV_DIV_EN
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            q_neg_q      <= q_neg_d;
            r_neg_q      <= r_neg_d;
`endif
        end
    end

    // Next-state, datapath and completion pulses; flush overrides everything.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mul_signed_d = mul_signed_q;
        done_d       = 1'b0;
        dbz_d        = 1'b0;
        // A sign- or zero-extended 2W x 2W product truncated to 2W bits is
        // the correct signed or unsigned result.
        w_ext_a = mul_signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        w_ext_b = mul_signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        w_prod  = w_ext_a * w_ext_b;
`ifdef MULDIV_DIV_EN
        rem_d        = rem_q;
        quo_d        = quo_q;
        q_neg_d      = q_neg_q;
        r_neg_d      = r_neg_q;
        w_div_signed = (op == OP_DIV);
        w_a_neg      = w_div_signed & a[WIDTH-1];
        w_b_neg      = w_div_signed & b[WIDTH-1];
        w_mag_a      = w_a_neg ? -a : a;
        w_mag_b      = w_b_neg ? -b : b;
        // The partial remainder stays below the divisor, so the shifted
        // value fits in WIDTH+1 bits and the top bit of the difference
        // is the borrow.
        w_shift      = {rem_q, quo_q[WIDTH-1]};
        w_diff       = w_shift - {1'b0, b_q};
`endif

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                a_d          = a;
                                b_d          = b;
                                mul_signed_d = (op == OP_MULT);
                                cnt_d        = CW'(MUL_LATENCY - 1);
                                state_d      = ST_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
                                a_d     = a;
                                b_d     = w_mag_b;
                                quo_d   = w_mag_a;
                                rem_d   = '0;
                                q_neg_d = w_a_neg ^ w_b_neg;
                                r_neg_d = w_a_neg;
                                cnt_d   = CW'(WIDTH - 1);
                                state_d = ST_DIV;
`else
                                done_d  = 1'b1;
`endif
                            end
                            OP_MTHI: hi_d = a;
                            OP_MTLO: lo_d = a;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt_q == '0) begin
                        {hi_d, lo_d} = w_prod;
                        done_d       = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
`ifdef MULDIV_DIV_EN
                ST_DIV: begin
                    if (b_q == '0) begin
                        done_d  = 1'b1;
                        dbz_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        if (!w_diff[WIDTH]) begin
                            rem_d = w_diff[WIDTH-1:0];
                            quo_d = {quo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_d = w_shift[WIDTH-1:0];
                            quo_d = {quo_q[WIDTH-2:0], 1'b0};
                        end
                        if (cnt_q == '0) begin
                            state_d = ST_FIX;
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end
                ST_FIX: begin
                    lo_d    = q_neg_q ? -quo_q : quo_q;
                    hi_d    = r_neg_q ? -rem_q : rem_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_hilo_ctrl
//  Description : Directed self-checking bench for muldiv_hilo_ctrl with a
//                scoreboard of expected HI/LO/div_by_zero results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_hilo_ctrl;

    localparam int         W      = 32;
    localparam int         ML     = 4;
    localparam logic [2:0] MULT   = 3'b000;
    localparam logic [2:0] MULTU  = 3'b001;
    localparam logic [2:0] DIV    = 3'b010;
    localparam logic [2:0] DIVU   = 3'b011;
    localparam logic [2:0] MTHI   = 3'b100;
    localparam logic [2:0] MTLO   = 3'b101;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic         flush = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           fails = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    muldiv_hilo_ctrl #(.WIDTH(W), .MUL_LATENCY(ML)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .flush(flush),
        .a(a), .b(b), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; leaves time just after that edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed, input int lat);
        exp_t e;
        e.hi = eh; e.lo = el; e.dbz = ed; e.lat = lat;
        sb.push_back(e);
        m_hi = eh; m_lo = el;
    endtask

    // Wait (bounded) for done, then pop the scoreboard and compare.
    task automatic wait_done(input string tag, input bit chk_pulse);
        int   k = 0;
        exp_t e;
        while (done !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        chk({tag, " done"}, 64'(done), 64'd1);
        total++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " latency"}, 64'(k), 64'(e.lat));
            chk({tag, " hi"}, 64'(hi), 64'(e.hi));
            chk({tag, " lo"}, 64'(lo), 64'(e.lo));
            chk({tag, " dbz"}, 64'(div_by_zero), 64'(e.dbz));
            chk({tag, " busy"}, 64'(busy), 64'd0);
        end
        if (chk_pulse) begin
            tick();
            chk({tag, " done_pulse"}, 64'(done), 64'd0);
            chk({tag, " dbz_pulse"}, 64'(div_by_zero), 64'd0);
        end
    endtask

    initial begin : stim
        logic [2:0] fop;
        int         ign_cyc;
        int         fl_cyc;

        // Reset state
        tick(); tick();
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst dbz", 64'(div_by_zero), 64'd0);
        #3 rst_n = 1'b1;
        tick();

        // Signed multiply: -3 * 5
        issue(MULT, 32'hFFFF_FFFD, 32'd5);
        push(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, ML);
        chk("mult busy", 64'(busy), 64'd1);
        wait_done("mult", 1'b1);

        // Unsigned multiply of all-ones
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        push(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, ML);
        wait_done("multu", 1'b1);

        // Signed multiply where MULT and MULTU differ: -1 * 2
        issue(MULT, 32'hFFFF_FFFF, 32'd2);
        push(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, ML);
        wait_done("mult_neg", 1'b1);

        // MTHI / MTLO: immediate write, no busy, no done
        issue(MTHI, 32'h0000_0011, 32'd0);
        chk("mthi hi", 64'(hi), 64'h11);
        chk("mthi busy", 64'(busy), 64'd0);
        chk("mthi done", 64'(done), 64'd0);
        issue(MTLO, 32'h0000_0022, 32'd0);
        chk("mtlo lo", 64'(lo), 64'h22);
        chk("mtlo hi kept", 64'(hi), 64'h11);
        m_hi = 32'h11; m_lo = 32'h22;

        // Reserved opcode is ignored
        issue(3'b110, 32'h5555_5555, 32'd7);
        chk("op110 hi", 64'(hi), 64'(m_hi));
        chk("op110 lo", 64'(lo), 64'(m_lo));
        chk("op110 busy", 64'(busy), 64'd0);
        chk("op110 done", 64'(done), 64'd0);

`ifdef MULDIV_DIV_EN
        // Divide by zero: HI/LO unchanged, done + div_by_zero together
        issue(DIV, 32'd5, 32'd0);
        push(m_hi, m_lo, 1'b1, 1);
        wait_done("div0", 1'b1);

        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, W + 1);
        wait_done("div_neg", 1'b1);

        issue(DIVU, 32'd100, 32'd7);
        push(32'd2, 32'd14, 1'b0, W + 1);
        wait_done("divu", 1'b1);

        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        push(32'd0, 32'h8000_0000, 1'b0, W + 1);
        wait_done("div_ovf", 1'b1);

        issue(DIV, 32'd7, 32'hFFFF_FFFE);
        push(32'd1, 32'hFFFF_FFFD, 1'b0, W + 1);
        wait_done("div_negdiv", 1'b1);

        fop = DIV; ign_cyc = 3; fl_cyc = 10;
`else
        // Divider absent: one-edge completion, HI/LO unchanged, no dbz
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        push(m_hi, m_lo, 1'b0, 0);
        chk("div_off busy", 64'(busy), 64'd0);
        wait_done("div_off", 1'b1);

        issue(DIVU, 32'd5, 32'd0);
        push(m_hi, m_lo, 1'b0, 0);
        wait_done("divu_off0", 1'b1);

        fop = MULT; ign_cyc = 1; fl_cyc = 2;
`endif

        // Flush mid-operation, with an ignored start while busy
        issue(fop, 32'd123, 32'd45);
        for (int c = 1; c < fl_cyc; c++) begin
            start = (c == ign_cyc);
            op = MULTU; a = 32'd9; b = 32'd9;
            tick();
            start = 1'b0;
        end
        chk("flush pre busy", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'd0);
        for (int c = 0; c < 40; c++) begin
            total++;
            assert (done === 1'b0 && busy === 1'b0) else begin
                fails++;
                $error("FAIL flush idle c=%0d observed done=%b busy=%b expected done=0 busy=0", c, done, busy);
            end
            tick();
        end
        chk("flush hi", 64'(hi), 64'(m_hi));
        chk("flush lo", 64'(lo), 64'(m_lo));

        // Flush on the same edge as a multiply completion wins
        issue(MULT, 32'd6, 32'd7);
        for (int c = 1; c < ML; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_last done", 64'(done), 64'd0);
        chk("flush_last busy", 64'(busy), 64'd0);
        chk("flush_last lo", 64'(lo), 64'(m_lo));
        chk("flush_last hi", 64'(hi), 64'(m_hi));

        // Start accepted in the cycle done is high (back-to-back)
        issue(MULTU, 32'd3, 32'd4);
        push(32'd0, 32'd12, 1'b0, ML);
        wait_done("b2b_first", 1'b0);
        issue(MULTU, 32'h0001_0000, 32'h0001_0000);
        push(32'd1, 32'd0, 1'b0, ML);
        chk("b2b busy", 64'(busy), 64'd1);
        wait_done("b2b_second", 1'b1);

        // MTHI then immediate MULT, then asynchronous reset mid-multiply
        issue(MTHI, 32'hDEAD_BEEF, 32'd0);
        chk("mthi2 hi", 64'(hi), 64'hDEAD_BEEF);
        issue(MULT, 32'd2, 32'd3);
        chk("mid busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst hi", 64'(hi), 64'd0);
        chk("arst lo", 64'(lo), 64'd0);
        chk("arst busy", 64'(busy), 64'd0);
        chk("arst done", 64'(done), 64'd0);
        tick();
        #2 rst_n = 1'b1;
        tick(); tick();
        chk("post rst busy", 64'(busy), 64'd0);
        chk("post rst done", 64'(done), 64'd0);
        chk("sb drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
`default_nettype wire
